// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } boot_state_e;

  localparam int BOOT_LEN_BYTES = 2;
  localparam int WORD_BYTES     = 4;

  // States in which the loader takes bytes from the stream.
  function automatic logic is_rx_state(boot_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_packer.sv
// Big-endian byte-to-word assembler; word_ready_o flags the byte that completes a word.
module byte_word_packer
  import boot_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_i,
  output logic [8*WORD_BYTES-1:0] word_o,
  output logic                    word_ready_o
);
  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [8*(WORD_BYTES-1)-1:0]   shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = {shift_q[8*(WORD_BYTES-2)-1:0], byte_i};
    end
  end

  // The completing byte is appended combinationally so the word is ready in its accept cycle.
  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = byte_valid_i && (cnt_q == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory
// and keeps the CPU in reset until a valid image is present.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN0  | receive len[7:0]
// LEN1  | receive len[15:8], range check
// DATA  | receive image bytes, write each completed word
// CSUM  | receive checksum byte and compare
// DONE  | image valid, CPU released
// ERR   | bad length or checksum, CPU held
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);
  localparam int LEN_W = 8 * BOOT_LEN_BYTES;

  boot_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;

  logic              in_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              cpu_hold_q, done_q, err_q;

  logic              accept;
  logic              load_start;
  logic              pack_valid;
  logic [31:0]       pack_word;
  logic              word_ready;
  logic [LEN_W-1:0]  len_full;

  assign accept   = bus.in_valid && in_ready_q;
  assign len_full = {bus.in_data, len_q[7:0]};

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (load_start),
    .byte_valid_i (pack_valid),
    .byte_i       (bus.in_data),
    .word_o       (pack_word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    wcnt_d     = wcnt_q;
    load_start = 1'b0;
    pack_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          load_start = 1'b1;
        end
      end
      ST_LEN0: begin
        if (accept) begin
          len_d   = {len_q[LEN_W-1:8], bus.in_data};
          csum_d  = csum_q ^ bus.in_data;
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ bus.in_data;
          if (32'(len_full) > (32'd1 << ADDR_W)) state_d = ST_ERR;
          else if (len_full == '0)               state_d = ST_CSUM;
          else                                   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          pack_valid = 1'b1;
          csum_d     = csum_q ^ bus.in_data;
          if (word_ready) begin
            wcnt_d = wcnt_q + 1'b1;
            if (32'(wcnt_q) + 32'd1 == 32'(len_q)) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_start) begin
      csum_d = '0;
      wcnt_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      csum_q       <= '0;
      wcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      wcnt_q     <= wcnt_d;
      in_ready_q <= is_rx_state(state_d);
      imem_we_q  <= word_ready;
      if (word_ready) begin
        imem_addr_q  <= wcnt_q[ADDR_W-1:0];
        imem_wdata_q <= pack_word;
      end
      cpu_hold_q <= (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_d == ST_ERR);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized load scenarios for imem_boot_loader checked against a stream-level model.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          acc_cyc[$];
  logic [31:0] ld_words[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(int'(bus.imem_addr));
      wr_data.push_back(bus.imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cyc.delete();
  endtask

  // Presents one byte after `gap` idle cycles and returns just after the edge that takes it.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      chk("ready_wait", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      start = 1'b0;
      return;
    end
    step();
    acc_cyc.push_back(cyc);
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Model: stream = len LE, words BE, XOR of all of those; expect one write per word.
  task automatic run_load(input logic [7:0] flip, input int gap_max, input bit noise);
    logic [7:0] s[$];
    logic [7:0] x;
    int len;
    bit ok;
    len = ld_words.size();
    ok  = (flip == 8'h00);
    clear_logs();
    s.push_back(8'(len));
    s.push_back(8'(len >> 8));
    foreach (ld_words[i]) begin
      for (int j = 3; j >= 0; j--) s.push_back(8'(ld_words[i] >> (8 * j)));
    end
    x = 8'h00;
    foreach (s[i]) x ^= s[i];

    pulse_start();
    chk("start_ready", 32'(bus.in_ready), 32'd1);
    chk("start_hold",  32'(cpu_hold), 32'd1);
    chk("start_done",  32'(done), 32'd0);
    chk("start_err",   32'(err), 32'd0);

    foreach (s[i]) send_byte(s[i], $urandom_range(0, gap_max), noise);
    send_byte(x ^ flip, $urandom_range(0, gap_max), noise);

    chk("end_done",  32'(done), 32'(ok));
    chk("end_err",   32'(err), 32'(!ok));
    chk("end_hold",  32'(cpu_hold), 32'(!ok));
    chk("end_ready", 32'(bus.in_ready), 32'd0);

    step();
    step();
    chk("wr_count", 32'(wr_addr.size()), 32'(len));
    for (int k = 0; k < len && k < wr_addr.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), 32'(wr_addr[k]), 32'(k));
      chk($sformatf("wr_data[%0d]", k), wr_data[k], ld_words[k]);
      // the strobe is seen in the cycle that follows the edge taking the word's last byte
      if (2 + 4 * k + 3 < acc_cyc.size())
        chk($sformatf("wr_cyc[%0d]", k), 32'(wr_cyc[k]), 32'(acc_cyc[2 + 4 * k + 3]));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    reset = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_we",    32'(bus.imem_we), 32'd0);
    chk("rst_addr",  32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    chk("rst_hold",  32'(cpu_hold), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_ready", 32'(bus.in_ready), 32'd0);

    // Normal load, then bad checksum, then recovery
    ld_words = '{32'h20080005, 32'h8C090004};
    run_load(8'h00, 0, 1'b0);
    run_load(8'h01, 0, 1'b0);
    run_load(8'h00, 1, 1'b0);

    // Zero length
    ld_words.delete();
    run_load(8'h00, 0, 1'b0);

    // Oversize length 257
    clear_logs();
    pulse_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    chk("ovs_err",   32'(err), 32'd1);
    chk("ovs_ready", 32'(bus.in_ready), 32'd0);
    chk("ovs_done",  32'(done), 32'd0);
    chk("ovs_hold",  32'(cpu_hold), 32'd1);
    repeat (3) step();
    chk("ovs_wr_count", 32'(wr_addr.size()), 32'd0);

    // Random short loads with stray start pulses during the stream
    for (int it = 0; it < 6; it++) begin
      ld_words.delete();
      repeat ($urandom_range(1, 8)) ld_words.push_back($urandom);
      run_load(($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 2, 1'b1);
    end

    // Full capacity with stalls
    ld_words.delete();
    repeat (256) ld_words.push_back($urandom);
    run_load(8'h00, 3, 1'b0);

    // Reset mid-load after 6 data bytes
    clear_logs();
    pulse_start();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0, 1'b0);
    reset = 1'b0;
    step();
    chk("mid_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_we",    32'(bus.imem_we), 32'd0);
    chk("mid_addr",  32'(bus.imem_addr), 32'd0);
    chk("mid_wdata", bus.imem_wdata, 32'd0);
    chk("mid_hold",  32'(cpu_hold), 32'd1);
    chk("mid_done",  32'(done), 32'd0);
    chk("mid_err",   32'(err), 32'd0);
    chk("mid_wr_count", 32'(wr_addr.size()), 32'd1);
    reset = 1'b1;
    step();
    step();
    chk("mid_idle_ready", 32'(bus.in_ready), 32'd0);
    ld_words.delete();
    repeat (3) ld_words.push_back($urandom);
    run_load(8'h00, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Upstream loader for the single-cycle CPU's instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes the words to consecutive word addresses starting at 0 and checks a trailing XOR checksum. Holds the CPU in reset until a complete, checksum-valid image is in memory.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  sole clock.
- reset  in  1  one clock; reset is synchronous and active-low.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored in other states.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts in_data; a byte transfers when in_valid && in_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  level; high only while the image is loaded and valid.
- err  out  1  level; high only while in ERR.

## Operation
- States and transitions:
  - IDLE: start → LEN0.
  - LEN0: accept byte → LEN1. This byte is len[7:0].
  - LEN1: accept byte → len[15:8]. Then:
    - len > 2**ADDR_W → ERR.
    - len == 0 → CSUM.
    - otherwise → DATA.
  - DATA: accept 4 bytes per word. First byte goes to bits [31:24], last byte to bits [7:0]. After the 4th byte of word k, write word k to address k. After word len−1 → CSUM.
  - CSUM: accept one byte. If it equals the running XOR → DONE, else → ERR.
  - DONE: stays here until start → LEN0.
  - ERR: stays here until start → LEN0.
- Running checksum:
  - XOR of every accepted byte, length bytes included; the checksum byte itself is excluded.
  - Cleared on entry to LEN0.
- Per-load counters are cleared on entry to LEN0: byte-in-word (2 bit) and word count (ADDR_W+1 bit).
- in_ready = 1 in LEN0, LEN1, DATA and CSUM; 0 in IDLE, DONE and ERR.
- cpu_hold = 0 only in DONE. On leaving DONE via start, cpu_hold rises in the same cycle the state changes.
- A start pulse outside IDLE/DONE/ERR is ignored. A load is not restarted mid-stream.
- Memory words beyond len are not written; they keep their previous contents.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, done 0, err 0, checksum 0.
- All outputs are registered.
- Write latency:
  - imem_we is high exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - imem_addr and imem_wdata are valid in that cycle and hold until the next write.
- Throughput: one byte per cycle. Back-to-back words produce a write strobe every 4 cycles.
- Final word: its write strobe coincides with the first cycle of CSUM. A checksum byte accepted in that cycle is legal.
- Completion: done/err assert, and cpu_hold falls on success, on the cycle after the checksum byte is accepted.
- Oversize length: err asserts the cycle after the second length byte is accepted. No write occurs.
- Stalls: in_valid low stalls in any receiving state. No timeout.
- Reset mid-load (reset low at any clk edge) returns all outputs to their reset values next cycle. A partially written image is not erased, but cpu_hold stays high.

## Structure
- Shared package `boot_pkg`:
  - state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - constant BOOT_LEN_BYTES = 2;
  - constant WORD_BYTES = 4.
- One sub-module, `byte_word_packer`:
  - 4-byte shift assembler with byte counter;
  - emits a word-ready pulse.
- The FSM, counters and checksum live in imem_boot_loader.

## Test plan
- Normal load: ADDR_W=8, len=2, words 0x20080005 and 0x8C090004, correct checksum → two imem_we pulses (addr 0 then 1, data as given); done=1, cpu_hold=0.
- Bad checksum: same stream with checksum byte XOR 0x01 → both writes occur, err=1, done=0, cpu_hold stays 1. A subsequent start plus a correct stream → done=1.
- Zero length: bytes 0x00, 0x00, 0x00 → no imem_we, done=1.
- Oversize: ADDR_W=8, len=257 (bytes 0x01, 0x01) → err=1 next cycle, in_ready=0, no writes.
- Stalls and full capacity: len=256 with random in_valid gaps → exactly 256 writes at addresses 0..255 in order, correct data, done=1.
- Reset mid-load: reset low after 6 data bytes → next cycle state IDLE, cpu_hold=1, imem_we=0, done=err=0. A fresh start loads correctly.
